// File: rtl/glyph_row_reader_if.sv
// Glyph row reader bus: glyph ROM read port, row stream handshake and scan control.
interface glyph_row_reader_if #(
  parameter int COLS   = 8,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 7
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_q;
  logic [COLS-1:0]   row_data;
  logic [RW-1:0]     row_idx;
  logic              row_valid;
  logic              row_ready;
  logic              busy;
  logic              done;

  // Reader side
  modport master (
    input  start, abort, rom_q, row_ready,
    output rom_addr, row_data, row_idx, row_valid, busy, done
  );

  // Environment side: controller, ROM and row consumer
  modport slave (
    output start, abort, rom_q, row_ready,
    input  rom_addr, row_data, row_idx, row_valid, busy, done
  );
endinterface

// File: rtl/glyph_row_reader.sv
// Scans a 1-bit glyph ROM row by row, packs each row (col 0 in MSB) and
// delivers it over a valid/ready handshake. The ROM read latency of one
// cycle is absorbed by a delayed capture strobe.
module glyph_row_reader #(
  parameter int COLS   = 8,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 7
) (
  input  logic                 clock,
  input  logic                 rst_n,
  glyph_row_reader_if.master   bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LAT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-2:0]   sh_q, sh_d;
  logic              cap_q, cap_d;
  logic [COLS-1:0]   rdata_q, rdata_d;
  logic [RW-1:0]     ridx_q, ridx_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [COLS-1:0]   sh_shift;

  // Next-state, address generation, capture and handshake decisions
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    addr_d   = addr_q;
    sh_d     = sh_q;
    cap_d    = 1'b0;
    rdata_d  = rdata_q;
    ridx_d   = ridx_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    // rom_q belongs to the address issued one cycle earlier, so capture
    // follows the issue strobe by one cycle.
    sh_shift = {sh_q, bus.rom_q};
    if (cap_q) sh_d = sh_shift[COLS-2:0];

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (bus.start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        cap_d = 1'b1;
        col_d = col_q + CW'(1);
        if (col_q == CW'(COLS - 1)) begin
          state_d = LAT;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      LAT: begin
        state_d = HOLD;
        rdata_d = sh_shift;
        ridx_d  = row_q;
        valid_d = 1'b1;
      end
      HOLD: begin
        if (bus.row_ready) begin
          valid_d = 1'b0;
          if (row_q == RW'(ROWS - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            state_d = FETCH;
            row_d   = row_q + RW'(1);
            col_d   = '0;
            addr_d  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(COLS);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over the handshake; row_data is intentionally left as is.
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cap_d   = 1'b0;
      addr_d  = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      cap_q   <= 1'b0;
      rdata_q <= '0;
      ridx_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      ridx_q  <= ridx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.row_data  = rdata_q;
  assign bus.row_idx   = ridx_q;
  assign bus.row_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_glyph_row_reader.sv
// Self-checking bench for glyph_row_reader: ROM model, row model, directed
// scenario sequence with random ROM contents.
module tb_glyph_row_reader;
  localparam int COLS   = 8;
  localparam int ROWS   = 16;
  localparam int ADDR_W = 7;

  logic clock;
  logic rst_n;
  int   tests;
  int   fails;
  bit   rom [0:127];

  glyph_row_reader_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus ();

  glyph_row_reader #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 1-cycle registered ROM
  always @(posedge clock) bus.rom_q <= rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Row r as the display expects it: column c lands in bit COLS-1-c.
  function automatic logic [7:0] exp_row(input int r);
    logic [7:0] v;
    for (int c = 0; c < COLS; c++) v[COLS-1-c] = rom[r*COLS + c];
    return v;
  endfunction

  task automatic load_random();
    for (int i = 0; i < 128; i++) rom[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 128; i++) rom[i] = 1'b0;
    rom[29] = 1'b1; rom[30] = 1'b1;
    rom[36] = 1'b1; rom[37] = 1'b1; rom[38] = 1'b1;
    rom[72] = 1'b1; rom[73] = 1'b1; rom[74] = 1'b1;
    for (int i = 76; i <= 79; i++) rom[i] = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_addr"},  32'(bus.rom_addr),  32'd0);
    chk({tag, "_valid"}, 32'(bus.row_valid), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
  endtask

  // Edge E0 is the tick inside this task.
  task automatic start_scan();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_addr", 32'(bus.rom_addr), 32'd0);
  endtask

  // Full scan with row checks; optional back-pressure on one row and
  // optional start pokes while rows 2 and 15 are in flight.
  task automatic scan(input int bp_row, input int bp_len, input bit poke);
    int e, r, held, dones;
    bit seen;
    logic [7:0] d_hold;
    e = 0; r = 0; held = 0; dones = 0; seen = 1'b0; d_hold = '0;
    bus.row_ready = 1'b1;
    start_scan();
    while (dones == 0 && e < 600) begin
      tick();
      e++;
      if (bus.done) begin
        dones++;
        chk("done_rows", 32'(r), 32'(ROWS));
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_addr", 32'(bus.rom_addr), 32'd0);
        if (bp_row < 0) chk("done_edge", 32'(e), 32'd160);
      end
      if (bus.row_valid) begin
        if (!seen) begin
          seen   = 1'b1;
          d_hold = exp_row(r);
          chk("row_idx",  32'(bus.row_idx),  32'(r));
          chk("row_data", 32'(bus.row_data), 32'(d_hold));
          chk("hold_addr", 32'(bus.rom_addr), 32'(r*COLS + COLS - 1));
          if (bp_row < 0) chk("valid_edge", 32'(e), 32'(9 + 10*r));
        end else begin
          chk("bp_data", 32'(bus.row_data), 32'(d_hold));
          chk("bp_idx",  32'(bus.row_idx),  32'(r));
          chk("bp_addr", 32'(bus.rom_addr), 32'(r*COLS + COLS - 1));
        end
        if (r == bp_row && held < bp_len) begin
          bus.row_ready = 1'b0;
          held++;
        end else begin
          bus.row_ready = 1'b1;
          r++;
          seen = 1'b0;
        end
      end else begin
        bus.row_ready = 1'($urandom_range(0, 1));
      end
      bus.start = poke && dones == 0 && (r == 2 || r == 15);
    end
    bus.start = 1'b0;
    bus.row_ready = 1'b1;
    chk("scan_done_seen", 32'(dones), 32'd1);
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    repeat (12) begin
      tick();
      if (bus.done || bus.busy) chk("no_restart", {30'd0, bus.busy, bus.done}, 32'd0);
    end
    chk("post_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    load_random();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.row_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    chk("reset_data", 32'(bus.row_data), 32'd0);
    chk("reset_idx",  32'(bus.row_idx),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Pattern scan with exact timing
    load_pattern();
    scan(-1, 0, 1'b0);

    // Back-pressure on row 4 of the pattern
    scan(4, 5, 1'b0);

    // Random contents, start poked mid-scan
    load_random();
    scan(-1, 0, 1'b1);

    // Abort during FETCH of row 7
    load_random();
    bus.row_ready = 1'b1;
    start_scan();
    repeat (73) tick();
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    chk("abort_pre_addr", 32'(bus.rom_addr), 32'(7*COLS + 3));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle_outputs("abort");
    chk("abort_keep_data", 32'(bus.row_data), 32'(exp_row(6)));
    repeat (5) tick();
    check_idle_outputs("abort_later");
    scan(-1, 0, 1'b0);

    // Asynchronous reset during HOLD of row 9
    load_random();
    bus.row_ready = 1'b1;
    start_scan();
    repeat (99) tick();
    chk("rst_pre_valid", 32'(bus.row_valid), 32'd1);
    chk("rst_pre_idx",   32'(bus.row_idx),   32'd9);
    chk("rst_pre_data",  32'(bus.row_data),  32'(exp_row(9)));
    bus.row_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    chk("async_rst_data", 32'(bus.row_data), 32'd0);
    chk("async_rst_idx",  32'(bus.row_idx),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    scan(-1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
